// File: rtl/rob_retire.sv
// rob_retire: in-order retire reorder buffer with out-of-order completion.
// Allocates entries at dispatch, records completions by tag, and retires up
// to two done entries per cycle onto the reg_file's two write ports.
// Optional feature: define ROB_FLUSH_EN to add a flush input that empties
// the buffer and suppresses retirement in the flush cycle.
module rob_retire #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_rd,
  input  logic             alloc_regwrite,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             cmpl_valid,
  input  logic [TAG_W-1:0] cmpl_tag,
  input  logic [31:0]      cmpl_data,
`ifdef ROB_FLUSH_EN
  input  logic             flush,
`endif
  output logic [4:0]       rd1,
  output logic [4:0]       rd2,
  output logic [31:0]      rd1_data,
  output logic [31:0]      rd2_data,
  output logic             regWrite1,
  output logic             regWrite2,
  output logic [1:0]       retire_cnt,
  output logic             rob_empty,
  output logic             rob_full
);

  localparam int CNT_W = TAG_W + 1;

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] done_q;
  logic [DEPTH-1:0] regwrite_q;
  logic [4:0]       rd_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];

  logic [TAG_W-1:0] head_q;
  logic [TAG_W-1:0] tail_q;
  logic [TAG_W-1:0] head1;
  logic [CNT_W-1:0] count_q;

  logic       flush_w;
  logic       slot1;
  logic       slot2;
  logic       alloc_fire;
  logic       cmpl_hit;
  logic [1:0] pop_cnt;

`ifdef ROB_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Retire eligibility, pop count and request qualification from registered state
  always_comb begin
    head1       = head_q + TAG_W'(1);
    slot1       = valid_q[head_q] & done_q[head_q];
    slot2       = slot1 & valid_q[head1] & done_q[head1];
    pop_cnt     = flush_w ? 2'd0 : {slot2, slot1 & ~slot2};
    alloc_ready = (count_q < CNT_W'(DEPTH));
    alloc_fire  = alloc_valid & alloc_ready & ~flush_w;
    cmpl_hit    = cmpl_valid & valid_q[cmpl_tag] & ~flush_w;
  end

  assign alloc_tag  = tail_q;
  assign rd1        = rd_q[head_q];
  assign rd2        = rd_q[head1];
  assign rd1_data   = data_q[head_q];
  assign rd2_data   = data_q[head1];
  assign regWrite1  = slot1 & regwrite_q[head_q] & ~flush_w;
  assign regWrite2  = slot2 & regwrite_q[head1] & ~flush_w;
  assign retire_cnt = pop_cnt;
  assign rob_empty  = (count_q == '0);
  assign rob_full   = (count_q == CNT_W'(DEPTH));

  // Control state: pointers, occupancy and per-entry valid/done bits.
  // Pop clears are issued last so they win over a late repeat completion.
  always_ff @(posedge clk) begin
    if (!reset_n || flush_w) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      if (cmpl_hit) begin
        done_q[cmpl_tag] <= 1'b1;
      end
      if (alloc_fire) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        tail_q          <= tail_q + TAG_W'(1);
      end
      if (pop_cnt != 2'd0) begin
        valid_q[head_q] <= 1'b0;
        done_q[head_q]  <= 1'b0;
      end
      if (pop_cnt == 2'd2) begin
        valid_q[head1] <= 1'b0;
        done_q[head1]  <= 1'b0;
      end
      head_q  <= head_q + TAG_W'(pop_cnt);
      count_q <= count_q + CNT_W'(alloc_fire) - CNT_W'(pop_cnt);
    end
  end

  // Entry payload: destination info at allocation, result data at completion
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      rd_q[tail_q]       <= alloc_rd;
      regwrite_q[tail_q] <= alloc_regwrite;
    end
    if (cmpl_hit) begin
      data_q[cmpl_tag] <= cmpl_data;
    end
  end

endmodule

// File: doc/rob_retire.md
# rob_retire

Reorder buffer that allocates entries in program order at dispatch and records out-of-order completion results from execution. It retires up to two completed entries per cycle, strictly in order, by driving the architectural register file's two retire write ports. It sits between dispatch/execute and `reg_file`. Its retire outputs connect directly to `rd1/rd1_data/regWrite1` and `rd2/rd2_data/regWrite2`.

## Interface
- DEPTH, 16, number of entries; must be a power of two, ≥ 4
- TAG_W, 4, tag width; must equal log2(DEPTH)
- clk  input  1  clock; all state updates on the rising edge
- reset_n  input  1  synchronous active-low reset
- alloc_valid  input  1  dispatch requests an entry this cycle
- alloc_rd  input  5  destination architectural register
- alloc_regwrite  input  1  instruction writes a register
- alloc_ready  output  1  an entry can be accepted this cycle
- alloc_tag  output  TAG_W  tag assigned to the request (the current tail)
- cmpl_valid  input  1  execution result valid
- cmpl_tag  input  TAG_W  tag of the completing entry
- cmpl_data  input  32  result value
- rd1, rd2  output  5  retire destination, slot 1/slot 2
- rd1_data, rd2_data  output  32  retire data
- regWrite1, regWrite2  output  1  register write enable per slot
- retire_cnt  output  2  entries popped this cycle (0–2)
- rob_empty, rob_full  output  1  occupancy flags
- flush  input  1  present only with ROB_FLUSH_EN

## Operation
- Per-entry state: valid, done, rd[4:0], regwrite, data[31:0].
- Pointers: head and tail, each TAG_W bits, wrapping mod DEPTH. Occupancy count is TAG_W+1 bits.
- **Allocation**
  - An allocation fires when alloc_valid && alloc_ready.
  - On fire, the tail entry is written with valid=1, done=0, rd, and regwrite; tail increments.
  - alloc_ready = (count < DEPTH), evaluated on the pre-retire count. A full buffer refuses allocation even if it retires in the same cycle.
- **Completion**
  - When cmpl_valid is high and entry[cmpl_tag] is valid: set done=1 and data=cmpl_data.
  - A completion to an invalid entry is ignored.
  - A repeat completion overwrites data.
- **Retire slots**
  - Slot 1 is eligible when entry[head] is valid && done.
  - Slot 2 is eligible when slot 1 is eligible and entry[head+1] is valid && done.
  - Slot 2 never retires without slot 1.
- **Retire outputs**
  - The outputs are combinational from registered state.
  - rdN and rdN_data always show the head/head+1 entry fields.
  - regWriteN = slot eligible && entry.regwrite.
  - An eligible entry with regwrite=0 (store, branch) still pops and counts in retire_cnt, with its regWrite deasserted.
- **Pop**
  - On the edge, retired entries are cleared (valid=0, done=0) and head advances by retire_cnt.
  - count_next = count + alloc_fire − retire_cnt.
- rd=0 entries are retired unchanged; reg_file discards the x0 write.

## Timing
- Reset (reset_n low at an edge) sets head=tail=count=0 and clears all valid/done bits. This may happen mid-operation; in-flight entries are discarded.
- Reset values of outputs:
  - regWrite1/2=0, retire_cnt=0, rob_empty=1, rob_full=0, alloc_ready=1, alloc_tag=0.
  - rd1/rd2/rd1_data/rd2_data show entry 0/1 fields, which are don't-care while regWrite is 0.
- Latency:
  - A completion captured at edge N makes the entry eligible in cycle N+1.
  - reg_file writes at edge N+2 relative to the completion cycle's start; no bypass from cmpl to retire.
- Allocate-then-complete to the same tag in the same cycle is illegal. Execute never sees the tag before allocation.
- Allocate and retire in the same cycle are both performed. Full and empty flags reflect count after the edge.
- Wrap-around: a tail of DEPTH−1 followed by one allocation gives tail=0. Slot 2 at head=DEPTH−1 reads entry 0.
- The two retire slots never target the same rd in a way that matters: slot 2 is the younger entry. If both write the same rd, reg_file applies slot 2 last, so the younger write wins.

## Configuration
- ROB_FLUSH_EN defined:
  - Adds the flush input.
  - flush high at an edge clears all valid/done bits and sets head=tail=count=0.
  - flush overrides alloc and cmpl in that cycle.
  - regWrite1/2 and retire_cnt are forced to 0 while flush is high, so no retire occurs in the flush cycle.
- ROB_FLUSH_EN undefined:
  - The flush port does not exist.
  - Reset is the only way to empty the buffer without retiring.

## Test plan
- Reset → rob_empty=1, alloc_ready=1, alloc_tag=0, regWrite1/2=0, retire_cnt=0.
- Allocate rd=5 (tag 0) and rd=6 (tag 1). Complete tag1=0xBBBB, then tag0=0xAAAA. → Next cycle: regWrite1=1 with rd1=5/0xAAAA and regWrite2=1 with rd2=6/0xBBBB; retire_cnt=2; rob_empty=1 after the edge.
- Allocate 3 entries. Complete only tags 1 and 2. → No retire, retire_cnt=0. After completing tag 0 → retire_cnt=2 (tags 0 and 1), then retire_cnt=1 (tag 2).
- Allocate DEPTH=16 entries → rob_full=1 and alloc_ready=0; a 17th alloc_valid is refused. Complete all, retire 8 cycles × 2, then allocate 3 more → tags 0, 1, 2 (wrap) and rob_full=0.
- Allocate a store (regwrite=0) followed by rd=7. Complete both. → retire_cnt=2, regWrite1=0, regWrite2=1 with rd2=7.
- With ROB_FLUSH_EN: allocate 4 and complete 2, then assert flush → retire_cnt=0 in the flush cycle, rob_empty=1 next cycle, and the next alloc_tag=0.
